// File: rtl/ctrl_pipeline_pkg.sv
// Shared definitions for the control pipeline: bundle layout, bit positions
// and forwarding-select encodings.
package ctrl_pipeline_pkg;

    localparam int CTRL_W = 11;

    // Bundle bit positions, LSB first
    localparam int CTRL_BRANCH    = 0;
    localparam int CTRL_JUMP      = 1;
    localparam int CTRL_MEMREAD   = 2;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_MEMWRITE  = 4;
    localparam int CTRL_ALUSRC    = 5;
    localparam int CTRL_REGWRITE  = 6;
    localparam int CTRL_RETURN    = 7;
    localparam int CTRL_PCSEL     = 8;
    localparam int CTRL_ALUOP_LSB = 9;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/ctrl_pipeline_stage_reg.sv
// One control stage register (valid, bundle, rd). A bubble or reset loads an
// all-zero entry; an invalid input also loads zero bundle and rd.
module ctrl_stage_reg
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bubble,
    input  logic                  in_valid,
    input  ctrl_t                 in_ctrl,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  valid,
    output ctrl_t                 ctrl,
    output logic [REG_ADDR_W-1:0] rd
);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            valid <= 1'b0;
            ctrl  <= '0;
            rd    <= '0;
        end else begin
            valid <= in_valid;
            ctrl  <= in_valid ? in_ctrl : '0;
            rd    <= in_valid ? in_rd : '0;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decoded control from ID through EX/MEM/WB, raises load-use stalls,
// applies redirect flushes and selects EX operand forwarding.
// Optional perf counters are built only when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  id_memread,
    input  logic                  id_memtoreg,
    input  logic                  id_memwrite,
    input  logic                  id_alusrc,
    input  logic                  id_regwrite,
    input  logic                  id_return,
    input  logic                  id_pcsel,
    input  logic [ALUOP_W-1:0]    id_aluop,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs2,
    input  logic                  ex_redirect,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]     mem_ctrl,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall,
    output logic                  flush_ifid,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    ctrl_t                 id_ctrl;
    logic                  ex_valid;
    logic                  ex_bubble;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic                  mem_valid;
    logic                  wb_valid;
    ctrl_t                 wb_ctrl;
    logic                  wb_ctrl_unused;

    assign id_ctrl = {id_aluop, id_pcsel, id_return, id_regwrite, id_alusrc,
                      id_memwrite, id_memtoreg, id_memread, id_jump, id_branch};

    // Load-use: the load in EX has not produced data yet; redirect wins
    // because the instruction in ID is about to be discarded anyway.
    always_comb begin
        stall = 1'b0;
        if (!ex_redirect && ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rd != '0) && id_valid) begin
            stall = (ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2));
        end
    end

    assign flush_ifid = ex_redirect;
    assign ex_bubble  = ex_redirect || stall;

    ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
        .clk      (clk),
        .reset    (reset),
        .bubble   (ex_bubble),
        .in_valid (id_valid),
        .in_ctrl  (id_ctrl),
        .in_rd    (id_rd),
        .valid    (ex_valid),
        .ctrl     (ex_ctrl),
        .rd       (ex_rd)
    );

    // Source indices follow the same bubble/invalid zeroing as the bundle
    always_ff @(posedge clk) begin
        if (reset || ex_bubble || !id_valid) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else begin
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
        end
    end

    ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .in_valid (ex_valid),
        .in_ctrl  (ex_ctrl),
        .in_rd    (ex_rd),
        .valid    (mem_valid),
        .ctrl     (mem_ctrl),
        .rd       (mem_rd)
    );

    ctrl_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .in_valid (mem_valid),
        .in_ctrl  (mem_ctrl),
        .in_rd    (mem_rd),
        .valid    (wb_valid),
        .ctrl     (wb_ctrl),
        .rd       (wb_rd)
    );

    assign wb_regwrite = wb_valid && wb_ctrl[CTRL_REGWRITE] && (wb_rd != '0);
    assign wb_memtoreg = wb_valid && wb_ctrl[CTRL_MEMTOREG];

    assign wb_ctrl_unused = ^{wb_ctrl[CTRL_W-1:CTRL_REGWRITE+1], wb_ctrl[CTRL_ALUSRC:CTRL_MEMWRITE],
                              wb_ctrl[CTRL_MEMREAD:CTRL_BRANCH]};

    function automatic logic writes_reg(input logic v, input ctrl_t c,
                                        input logic [REG_ADDR_W-1:0] rd,
                                        input logic [REG_ADDR_W-1:0] rs);
        return v && c[CTRL_REGWRITE] && (rd != '0) && (rd == rs);
    endfunction

    // The younger producer (MEM) holds the newer value and must win
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (writes_reg(mem_valid, mem_ctrl, mem_rd, ex_rs1)) begin
            fwd_a = FWD_MEM;
        end else if (writes_reg(wb_valid, wb_ctrl, wb_rd, ex_rs1)) begin
            fwd_a = FWD_WB;
        end
        if (writes_reg(mem_valid, mem_ctrl, mem_rd, ex_rs2)) begin
            fwd_b = FWD_MEM;
        end else if (writes_reg(wb_valid, wb_ctrl, wb_rd, ex_rs2)) begin
            fwd_b = FWD_WB;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
            if (ex_redirect && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Randomized and directed bench for ctrl_pipeline, checked against an
// instruction-level model of the EX/MEM/WB occupancy.
module tb_ctrl_pipeline;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int K_NOP = 0, K_LW = 1, K_ADD = 2, K_SW = 3, K_BEQ = 4;

  // clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic id_branch, id_jump, id_memread, id_memtoreg, id_memwrite;
  logic id_alusrc, id_regwrite, id_return, id_pcsel;
  logic [1:0] id_aluop;
  logic id_valid, id_uses_rs2, ex_redirect;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [10:0] ex_ctrl, mem_ctrl;
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
  logic wb_regwrite, wb_memtoreg, stall, flush_ifid;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_count, flush_count;

  ctrl_pipeline #(.REG_ADDR_W(RW), .ALUOP_W(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_branch(id_branch), .id_jump(id_jump), .id_memread(id_memread),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_return(id_return), .id_pcsel(id_pcsel),
    .id_aluop(id_aluop), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses_rs2(id_uses_rs2), .ex_redirect(ex_redirect),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .stall(stall), .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // reference model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
  typedef struct packed {
    logic valid;
    logic [10:0] ctrl;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
  } instr_t;

  instr_t pipe_q[$];
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;
  int compared = 0;
  int mismatched = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] id_bundle();
    return {id_aluop, id_pcsel, id_return, id_regwrite, id_alusrc,
            id_memwrite, id_memtoreg, id_memread, id_jump, id_branch};
  endfunction

  function automatic logic produces(instr_t s, logic [RW-1:0] r);
    return s.valid && s.ctrl[6] && (s.rd != 0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] exp_fwd(logic [RW-1:0] r);
    if (produces(pipe_q[1], r)) return 2'b10;
    if (produces(pipe_q[2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    instr_t e = pipe_q[0];
    if (ex_redirect || !id_valid || !e.valid || !e.ctrl[2] || e.rd == 0) return 1'b0;
    return (e.rd == id_rs1) || (id_uses_rs2 && e.rd == id_rs2);
  endfunction

  task automatic model_clear();
    pipe_q = {instr_t'(0), instr_t'(0), instr_t'(0)};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic model_edge();
    instr_t nx;
    logic s;
    int unsigned cmax;
    cmax = (1 << CW) - 1;
    if (reset) begin
      model_clear();
    end else begin
      s = exp_stall();
      nx = '0;
      if (!ex_redirect && !s && id_valid) nx = {1'b1, id_bundle(), id_rd, id_rs1, id_rs2};
      if (s && m_stall_cnt < cmax) m_stall_cnt++;
      if (ex_redirect && m_flush_cnt < cmax) m_flush_cnt++;
      pipe_q.push_front(nx);
      void'(pipe_q.pop_back());
    end
  endtask

  task automatic check_all();
    check_eq("ex_ctrl", ex_ctrl, pipe_q[0].ctrl);
    check_eq("ex_rd", ex_rd, pipe_q[0].rd);
    check_eq("mem_ctrl", mem_ctrl, pipe_q[1].ctrl);
    check_eq("mem_rd", mem_rd, pipe_q[1].rd);
    check_eq("wb_rd", wb_rd, pipe_q[2].rd);
    check_eq("wb_regwrite", wb_regwrite, pipe_q[2].valid && pipe_q[2].ctrl[6] && pipe_q[2].rd != 0);
    check_eq("wb_memtoreg", wb_memtoreg, pipe_q[2].valid && pipe_q[2].ctrl[3]);
    check_eq("stall", stall, exp_stall());
    check_eq("flush_ifid", flush_ifid, ex_redirect);
    if (pipe_q[0].valid) begin
      check_eq("fwd_a", fwd_a, exp_fwd(pipe_q[0].rs1));
      check_eq("fwd_b", fwd_b, exp_fwd(pipe_q[0].rs2));
    end
`ifdef CTRL_PIPE_PERF_EN
    check_eq("stall_count", stall_count, m_stall_cnt);
    check_eq("flush_count", flush_count, m_flush_cnt);
`else
    check_eq("stall_count", stall_count, 0);
    check_eq("flush_count", flush_count, 0);
`endif
  endtask

  // one cycle: check at negedge, advance model, return 1 time unit after posedge
  task automatic tick();
    @(negedge clk);
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input int kind, input logic v, input logic [RW-1:0] rd,
                       input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
    {id_branch, id_jump, id_memread, id_memtoreg, id_memwrite} = '0;
    {id_alusrc, id_regwrite, id_return, id_pcsel, id_uses_rs2} = '0;
    id_aluop = 2'b00;
    ex_redirect = 1'b0;
    id_valid = v;
    id_rd = rd;
    id_rs1 = rs1;
    id_rs2 = rs2;
    case (kind)
      K_LW:  begin id_memread = 1; id_memtoreg = 1; id_alusrc = 1; id_regwrite = 1; end
      K_ADD: begin id_regwrite = 1; id_aluop = 2'b10; id_uses_rs2 = 1; end
      K_SW:  begin id_memwrite = 1; id_alusrc = 1; id_uses_rs2 = 1; end
      K_BEQ: begin id_branch = 1; id_aluop = 2'b01; id_uses_rs2 = 1; end
      default: ;
    endcase
  endtask

  task automatic drive_random();
    {id_branch, id_jump, id_memread, id_memtoreg, id_memwrite} = 5'($urandom);
    {id_alusrc, id_regwrite, id_return, id_pcsel, id_uses_rs2} = 5'($urandom);
    id_aluop = 2'($urandom);
    id_valid = ($urandom_range(0, 7) != 0);
    id_rd = RW'($urandom_range(0, 7));
    id_rs1 = RW'($urandom_range(0, 7));
    id_rs2 = RW'($urandom_range(0, 7));
    ex_redirect = ($urandom_range(0, 9) == 0);
    reset = ($urandom_range(0, 99) == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(K_NOP, 1'b0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    drive(K_NOP, 1'b0, 0, 0, 0);
    model_clear();

    // reset mid-stream
    do_reset();
    drive(K_LW, 1'b1, 5, 1, 0);
    tick();
    drive(K_ADD, 1'b1, 6, 5, 7);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(K_NOP, 1'b0, 0, 0, 0);
    #1;
    check_eq("rst_ex_ctrl", ex_ctrl, 0);
    check_eq("rst_mem_ctrl", mem_ctrl, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_fwd_a", fwd_a, 0);
    check_eq("rst_wb_rd", wb_rd, 0);

    // load-use: lw x5; add x6,x5,x7
    do_reset();
    drive(K_LW, 1'b1, 5, 1, 0);
    tick();
    drive(K_ADD, 1'b1, 6, 5, 7);
    #1;
    check_eq("lu_stall", stall, 1);
    tick();
    check_eq("lu_bubble", ex_ctrl, 0);
    check_eq("lu_stall_once", stall, 0);
    tick();
    drive(K_NOP, 1'b0, 0, 0, 0);
    #1;
    check_eq("lu_fwd_wb", fwd_a, 2'b01);

    // MEM forward, then x0 never forwards
    do_reset();
    drive(K_ADD, 1'b1, 3, 1, 2);
    tick();
    drive(K_ADD, 1'b1, 4, 3, 3);
    tick();
    drive(K_NOP, 1'b0, 0, 0, 0);
    #1;
    check_eq("mem_fwd_a", fwd_a, 2'b10);
    check_eq("mem_fwd_b", fwd_b, 2'b10);
    drive(K_ADD, 1'b1, 0, 1, 1);
    tick();
    drive(K_ADD, 1'b1, 1, 0, 0);
    tick();
    drive(K_NOP, 1'b0, 0, 0, 0);
    #1;
    check_eq("x0_fwd_a", fwd_a, 2'b00);
    check_eq("x0_fwd_b", fwd_b, 2'b00);

    // MEM beats WB on the same register
    do_reset();
    drive(K_ADD, 1'b1, 2, 1, 1);
    tick();
    drive(K_ADD, 1'b1, 2, 3, 3);
    tick();
    drive(K_ADD, 1'b1, 9, 2, 2);
    tick();
    drive(K_NOP, 1'b0, 0, 0, 0);
    #1;
    check_eq("prio_fwd_a", fwd_a, 2'b10);
    check_eq("prio_fwd_b", fwd_b, 2'b10);

    // redirect beats load-use stall
    do_reset();
    drive(K_LW, 1'b1, 5, 1, 0);
    tick();
    drive(K_ADD, 1'b1, 6, 5, 7);
    ex_redirect = 1'b1;
    #1;
    check_eq("redir_stall", stall, 0);
    check_eq("redir_flush", flush_ifid, 1);
    tick();
    drive(K_NOP, 1'b0, 0, 0, 0);
    #1;
    check_eq("redir_bubble", ex_ctrl, 0);
`ifdef CTRL_PIPE_PERF_EN
    check_eq("redir_flush_cnt", flush_count, 1);
    check_eq("redir_stall_cnt", stall_count, 0);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive_random();
      tick();
    end
    reset = 1'b0;

    // repeated self-dependent loads: a stall every other cycle
    do_reset();
    drive(K_LW, 1'b1, 1, 1, 0);
    repeat (45) tick();
`ifdef CTRL_PIPE_PERF_EN
    check_eq("sat_stall_cnt", stall_count, 15);
`else
    check_eq("sat_stall_cnt", stall_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
